perceptron_fwd: RTL and testbench

Forward-pass engine for the two-input perceptron. It sweeps sample addresses across the x1 and x2 input memories, which are 16-bit Q6.9 signed and have a 1-cycle registered read. For each sample it computes y = w1*x1 + w2*x2 + bias in Q6.9 with saturation, applies a step activation, and writes the result to the output memory. It sits directly downstream of the input-data memories and drives their mem_ena/wr_rd/addr.

---
 rtl/perceptron_pkg.sv | 35 +++
 rtl/perceptron_fwd_q9_mac_sat.sv | 68 ++++++
 rtl/perceptron_fwd.sv | 165 ++++++++++++++++
 tb/tb_perceptron_fwd.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared widths, Q6.9 constants and FSM states for the perceptron blocks
// Contents:
//   ADDR_W, DATA_W, FRAC, DEPTH : data-memory geometry and Q6.9 format
//   PROD_W, ACC_W               : product and accumulator widths
//   ONE_Q, NEG_ONE_Q            : +1.0 and -1.0 in Q6.9
//   fwd_state_e                 : sweep FSM states (shared with the training-update block)
//   clamp_count()               : limits a requested sample count to DEPTH
package perceptron_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int FRAC   = 9;
  localparam int DEPTH  = 1024;

  localparam int PROD_W = 2 * DATA_W;
  // Two full products plus a shifted bias need two guard bits above PROD_W.
  localparam int ACC_W  = 2 * DATA_W + 2;

  localparam logic signed [DATA_W-1:0] ONE_Q     = 16'sd512;
  localparam logic signed [DATA_W-1:0] NEG_ONE_Q = -16'sd512;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_MAC     = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } fwd_state_e;

  function automatic logic [ADDR_W-1:0] clamp_count(input logic [ADDR_W-1:0] req);
    return (req > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : req;
  endfunction

endpackage

// File: rtl/perceptron_fwd_q9_mac_sat.sv
// rtl/perceptron_fwd_q9_mac_sat.sv - two-product Q6.9 multiply-accumulate with bias, shift and saturation
// Ports:
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_cap_en              : register w1*x1 and w2*x2 (CAPTURE cycle)
//   i_mac_en              : register the saturated sum (MAC cycle)
//   i_w1, i_w2, i_bias    : latched Q6.9 weights and bias
//   i_x1, i_x2            : Q6.9 sample data from the input memories
//   o_sum                 : last saturated Q6.9 pre-activation sum
module q9_mac_sat
  import perceptron_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cap_en,
  input  logic                     i_mac_en,
  input  logic signed [DATA_W-1:0] i_w1,
  input  logic signed [DATA_W-1:0] i_w2,
  input  logic signed [DATA_W-1:0] i_bias,
  input  logic signed [DATA_W-1:0] i_x1,
  input  logic signed [DATA_W-1:0] i_x2,
  output logic signed [DATA_W-1:0] o_sum
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  logic signed [PROD_W-1:0] r_p1;
  logic signed [PROD_W-1:0] r_p2;
  logic signed [DATA_W-1:0] r_sum;
  logic signed [ACC_W-1:0]  w_s;
  logic signed [ACC_W-1:0]  w_t;
  logic signed [DATA_W-1:0] w_sat;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_p1 <= '0;
      r_p2 <= '0;
    end else if (i_cap_en) begin
      r_p1 <= i_w1 * i_x1;
      r_p2 <= i_w2 * i_x2;
    end
  end

  // Products are Q12.18; bias is lifted to the same scale before the add,
  // then the arithmetic shift drops back to Q6.9 rounding toward -inf.
  always_comb begin
    w_s = ACC_W'(r_p1) + ACC_W'(r_p2) + (ACC_W'(i_bias) <<< FRAC);
    w_t = w_s >>> FRAC;
    if (w_t > SAT_MAX) begin
      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (w_t < SAT_MIN) begin
      w_sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      w_sat = w_t[DATA_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (i_mac_en) begin
      r_sum <= w_sat;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/perceptron_fwd.sv
// rtl/perceptron_fwd.sv - forward-pass sweep: read x1/x2, MAC with bias, step activation, write result
// Ports:
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_start, i_num_samples    : launch a sweep of min(num_samples, DEPTH) samples (IDLE only)
//   i_w1, i_w2, i_bias        : Q6.9 weights/bias, latched with i_start
//   o_mem_ena/_wr_rd/_addr    : x1/x2 memory read port (read data one cycle later)
//   i_x1_data, i_x2_data      : x1/x2 memory read data
//   o_out_ena/_wr_rd/_addr    : output memory write port
//   o_out_data                : activation value (ACT_HI for y >= 0, else ACT_LO)
//   o_sum_q                   : last saturated pre-activation sum
//   o_busy, o_done            : sweep in progress / one-cycle end-of-sweep pulse
//   o_pos_count               : samples with y >= 0 in the last sweep
module perceptron_fwd
  import perceptron_pkg::*;
#(
  parameter logic signed [DATA_W-1:0] ACT_HI = ONE_Q,
  parameter logic signed [DATA_W-1:0] ACT_LO = NEG_ONE_Q
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [ADDR_W-1:0]        i_num_samples,
  input  logic signed [DATA_W-1:0] i_w1,
  input  logic signed [DATA_W-1:0] i_w2,
  input  logic signed [DATA_W-1:0] i_bias,
  output logic                     o_mem_ena,
  output logic                     o_mem_wr_rd,
  output logic [ADDR_W-1:0]        o_mem_addr,
  input  logic signed [DATA_W-1:0] i_x1_data,
  input  logic signed [DATA_W-1:0] i_x2_data,
  output logic                     o_out_ena,
  output logic                     o_out_wr_rd,
  output logic [ADDR_W-1:0]        o_out_addr,
  output logic signed [DATA_W-1:0] o_out_data,
  output logic signed [DATA_W-1:0] o_sum_q,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ADDR_W-1:0]        o_pos_count
);

  fwd_state_e               r_state;
  fwd_state_e               w_state_nxt;
  logic [ADDR_W-1:0]        r_idx;
  logic [ADDR_W-1:0]        r_n;
  logic [ADDR_W-1:0]        r_pos_count;
  logic signed [DATA_W-1:0] r_w1;
  logic signed [DATA_W-1:0] r_w2;
  logic signed [DATA_W-1:0] r_bias;
  logic [ADDR_W-1:0]        w_n_req;
  logic signed [DATA_W-1:0] w_sum;
  logic                     w_last;
  logic                     w_fetch;
  logic                     w_cap;
  logic                     w_mac;
  logic                     w_write;
  logic                     w_done;
  logic                     w_sum_pos;

  assign w_n_req   = clamp_count(i_num_samples);
  // r_n is at least 1 whenever WRITE is reachable, so n-1 never wraps there.
  assign w_last    = (r_idx == (r_n - ADDR_W'(1)));
  assign w_sum_pos = !w_sum[DATA_W-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    w_cap       = 1'b0;
    w_mac       = 1'b0;
    w_write     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (w_n_req == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        w_fetch     = 1'b1;
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_cap       = 1'b1;
        w_state_nxt = S_MAC;
      end
      S_MAC: begin
        w_mac       = 1'b1;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_write     = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operands are latched at start so input changes during a sweep are ignored.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx       <= '0;
      r_n         <= '0;
      r_pos_count <= '0;
      r_w1        <= '0;
      r_w2        <= '0;
      r_bias      <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_w1        <= i_w1;
        r_w2        <= i_w2;
        r_bias      <= i_bias;
        r_n         <= w_n_req;
        r_idx       <= '0;
        r_pos_count <= '0;
      end else if (w_write) begin
        if (w_sum_pos) begin
          r_pos_count <= r_pos_count + ADDR_W'(1);
        end
        if (!w_last) begin
          r_idx <= r_idx + ADDR_W'(1);
        end
      end
    end
  end

  q9_mac_sat u_mac (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_cap_en (w_cap),
    .i_mac_en (w_mac),
    .i_w1     (r_w1),
    .i_w2     (r_w2),
    .i_bias   (r_bias),
    .i_x1     (i_x1_data),
    .i_x2     (i_x2_data),
    .o_sum    (w_sum)
  );

  // Addresses and data are gated to zero outside their strobe cycle.
  assign o_mem_ena   = w_fetch;
  assign o_mem_wr_rd = 1'b0;
  assign o_mem_addr  = w_fetch ? r_idx : '0;
  assign o_out_ena   = w_write;
  assign o_out_wr_rd = w_write;
  assign o_out_addr  = w_write ? r_idx : '0;
  assign o_out_data  = w_write ? (w_sum_pos ? ACT_HI : ACT_LO) : '0;
  assign o_sum_q     = w_sum;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = w_done;
  assign o_pos_count = r_pos_count;

endmodule

// File: tb/tb_perceptron_fwd.sv
// tb/tb_perceptron_fwd.sv - self-checking bench for perceptron_fwd
module tb_perceptron_fwd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] num;
  logic [15:0] w1, w2, bias;
  logic [15:0] x1_q, x2_q;
  logic        mem_ena, mem_wr_rd, out_ena, out_wr_rd, busy, done;
  logic [10:0] mem_addr, out_addr, pos_count;
  logic [15:0] out_data, sum_q;

  always #5 clk = ~clk;

  perceptron_fwd dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_samples(num),
    .i_w1(w1), .i_w2(w2), .i_bias(bias),
    .o_mem_ena(mem_ena), .o_mem_wr_rd(mem_wr_rd), .o_mem_addr(mem_addr),
    .i_x1_data(x1_q), .i_x2_data(x2_q),
    .o_out_ena(out_ena), .o_out_wr_rd(out_wr_rd), .o_out_addr(out_addr),
    .o_out_data(out_data), .o_sum_q(sum_q), .o_busy(busy), .o_done(done),
    .o_pos_count(pos_count)
  );

  logic signed [15:0] x1_mem [0:1023];
  logic signed [15:0] x2_mem [0:1023];
  longint exp_sum [0:1023];
  int rd_cnt [0:1023];
  int wr_cnt [0:1023];
  int rd_base_cnt [0:1023];
  int wr_base_cnt [0:1023];
  int n_vec = 0, n_err = 0;
  int tick = 0, start_tick = 0;
  int rd_total = 0, wr_total = 0, rd_base = 0, wr_base = 0;
  int exp_n = 0, exp_pos = 0, last_done_c = 0;
  bit sweep_on = 1'b0;
  longint last_out_data = 0, last_out_addr = 0;

  // Registered-read input memories.
  always @(posedge clk) begin
    tick <= tick + 1;
    if (mem_ena) begin
      x1_q <= x1_mem[mem_addr[9:0]];
      x2_q <= x2_mem[mem_addr[9:0]];
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: exact integer sum, floor-divide by 2^9, clamp to 16-bit signed.
  function automatic longint model(longint a, longint b, longint c, longint xa, longint xb);
    longint s, t;
    s = a * xa + b * xb + c * 512;
    t = s / 512;
    if ((s % 512) != 0 && s < 0) t = t - 1;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return t;
  endfunction

  always @(negedge clk) begin : cmp
    int c, k;
    c = tick - start_tick + 1;
    if (mem_ena) begin
      if (!sweep_on) chk("stray_read", mem_ena, 0);
      else begin
        k = rd_total - rd_base;
        if (k >= exp_n) chk("extra_read", k, exp_n - 1);
        else begin
          chk("rd_addr", mem_addr, k);
          chk("rd_cycle", c, 4 * k + 1);
          chk("rd_wr_rd", mem_wr_rd, 0);
        end
      end
      rd_total++;
      rd_cnt[mem_addr[9:0]]++;
    end
    if (out_ena) begin
      chk("ena_exclusive", mem_ena, 0);
      if (!sweep_on) chk("stray_write", out_ena, 0);
      else begin
        k = wr_total - wr_base;
        if (k >= exp_n) chk("extra_write", k, exp_n - 1);
        else begin
          chk("wr_addr", out_addr, k);
          chk("wr_cycle", c, 4 * k + 4);
          chk("wr_wr_rd", out_wr_rd, 1);
          chk("wr_sum", $signed(sum_q), exp_sum[k]);
          chk("wr_data", $signed(out_data), (exp_sum[k] >= 0) ? 512 : -512);
        end
      end
      last_out_data = $signed(out_data);
      last_out_addr = out_addr;
      wr_total++;
      wr_cnt[out_addr[9:0]]++;
    end
  end

  task automatic prep(input int nreq, input int a, input int b, input int c);
    exp_n = (nreq > 1024) ? 1024 : nreq;
    exp_pos = 0;
    for (int k = 0; k < exp_n; k++) begin
      exp_sum[k] = model(a, b, c, x1_mem[k], x2_mem[k]);
      if (exp_sum[k] >= 0) exp_pos++;
    end
    rd_base = rd_total;
    wr_base = wr_total;
    for (int i = 0; i < 1024; i++) begin
      rd_base_cnt[i] = rd_cnt[i];
      wr_base_cnt[i] = wr_cnt[i];
    end
  endtask

  task automatic kick(input int nreq, input int a, input int b, input int c);
    @(negedge clk);
    num = 11'(nreq); w1 = 16'(a); w2 = 16'(b); bias = 16'(c); start = 1'b1;
    @(posedge clk);
    #1;
    start_tick = tick;
    sweep_on = 1'b1;
    start = 1'b0;
    num = 11'd5; w1 = 16'h7fff; w2 = 16'h8000; bias = 16'h1111;
  endtask

  task automatic run_sweep(input int nreq, input int a, input int b, input int c);
    int bad_rd, bad_wr;
    prep(nreq, a, b, c);
    kick(nreq, a, b, c);
    last_done_c = -1;
    for (int cy = 1; cy <= 5000; cy++) begin
      @(negedge clk);
      if (done) begin
        last_done_c = cy;
        break;
      end
      start = (cy == 6);
    end
    start = 1'b0;
    chk("done_cycle", last_done_c, 4 * exp_n + 1);
    chk("pos_count", pos_count, exp_pos);
    if (exp_n > 0) chk("sum_hold", $signed(sum_q), exp_sum[exp_n-1]);
    bad_rd = 0;
    bad_wr = 0;
    for (int i = 0; i < 1024; i++) begin
      if (rd_cnt[i] - rd_base_cnt[i] != ((i < exp_n) ? 1 : 0)) bad_rd++;
      if (wr_cnt[i] - wr_base_cnt[i] != ((i < exp_n) ? 1 : 0)) bad_wr++;
    end
    chk("read_each_once", bad_rd, 0);
    chk("write_each_once", bad_wr, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    sweep_on = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_mem_ena"}, mem_ena, 0);
    chk({tag, "_out_ena"}, out_ena, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum_q"}, sum_q, 0);
    chk({tag, "_pos"}, pos_count, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_addrs"}, mem_addr | out_addr, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num = '0; w1 = '0; w2 = '0; bias = '0;
    x1_q = '0; x2_q = '0;
    for (int i = 0; i < 1024; i++) begin
      x1_mem[i] = '0; x2_mem[i] = '0; rd_cnt[i] = 0; wr_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    rst_n = 1'b1;

    // Single sample: 0.75 + 0.5 - 1.0 = 0.25
    x1_mem[0] = 16'sd384; x2_mem[0] = 16'sd256;
    run_sweep(1, 512, 512, -512);
    chk("t1_sum_lit", $signed(sum_q), 128);
    chk("t1_data_lit", last_out_data, 512);
    chk("t1_addr_lit", last_out_addr, 0);
    chk("t1_pos_lit", pos_count, 1);
    chk("t1_done_lit", last_done_c, 5);

    // y == 0 maps positive; slightly negative floors to -1 LSB
    x1_mem[0] = 16'sd256; x2_mem[0] = 16'sd256;
    run_sweep(1, 512, 512, -512);
    chk("t2_sum_lit", $signed(sum_q), 0);
    chk("t2_data_lit", last_out_data, 512);
    run_sweep(1, 512, 511, -512);
    chk("t2b_sum_lit", $signed(sum_q), -1);
    chk("t2b_data_lit", last_out_data, -512);
    chk("t2b_pos_lit", pos_count, 0);

    // Saturation corners
    x1_mem[0] = 16'sd32767; x2_mem[0] = 16'sd32767;
    run_sweep(1, 32767, 32767, 32767);
    chk("sat_hi_lit", $signed(sum_q), 32767);
    x1_mem[0] = -16'sd32768; x2_mem[0] = -16'sd32768;
    run_sweep(1, -32768, -32768, -32768);
    chk("sat_negneg_lit", $signed(sum_q), 32767);
    x1_mem[0] = 16'sd32767; x2_mem[0] = 16'sd0;
    run_sweep(1, -32768, 0, 0);
    chk("sat_lo_lit", $signed(sum_q), -32768);

    // Full-depth sweep with alternating sign, then clamped request
    for (int i = 0; i < 1024; i++) begin
      x1_mem[i] = (i % 2 == 0) ? 16'sd256 : -16'sd256;
      x2_mem[i] = (i % 2 == 0) ? 16'sd100 : -16'sd300;
    end
    run_sweep(1024, 512, 512, 0);
    chk("full_pos_lit", pos_count, 512);
    chk("full_done_lit", last_done_c, 4097);
    run_sweep(2047, 512, 512, 0);
    chk("clamp_pos_lit", pos_count, 512);
    chk("clamp_done_lit", last_done_c, 4097);

    // Empty sweep
    run_sweep(0, 512, 512, 0);
    chk("empty_done_lit", last_done_c, 1);
    chk("empty_pos_lit", pos_count, 0);

    // Reset during CAPTURE of sample 3 (cycle 14)
    for (int i = 0; i < 6; i++) begin
      x1_mem[i] = (i % 2 == 0) ? 16'sd300 : -16'sd700;
      x2_mem[i] = 16'sd50;
    end
    prep(6, 512, 512, 0);
    kick(6, 512, 512, 0);
    repeat (13) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_zero("midrst");
    chk("midrst_writes", wr_total - wr_base, 3);
    chk("midrst_no_wr3", wr_cnt[3] - wr_base_cnt[3], 0);
    chk("midrst_reads", rd_total - rd_base, 4);
    sweep_on = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_quiet", mem_ena | out_ena | busy, 0);
    for (int i = 0; i < 4; i++) begin
      x1_mem[i] = (i < 2) ? -16'sd512 : 16'sd512;
      x2_mem[i] = 16'sd128;
    end
    run_sweep(4, 512, 256, 64);
    chk("rerun_pos_lit", pos_count, 2);
    chk("rerun_done_lit", last_done_c, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
